// File: rtl/loop_predictor_column_pkg.sv
// loop_predictor_column_pkg: shared types and sizes for the loop predictor column
package loop_predictor_column_pkg;
  localparam int N_SETS = 16;
  localparam int SET_W = 4;
  localparam int IDX_W = 36;
  localparam int TAG_W = 10;
  localparam int CNT_W = 10;
  localparam logic [2:0] CONF_MAX = 3'd7;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [2:0]       conf;
    logic [2:0]       age;
    logic [CNT_W-1:0] p_cnt;
    logic [CNT_W-1:0] s_cnt;
  } loop_entry_t;
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction
endpackage

// File: rtl/loop_predictor_column.sv
// loop_predictor_column: one fetch slot of the loop predictor; flips the base direction at a learned trip count
// Ports: clock/reset (sync, active-high); io_f2_req_idx lookup index (f2);
// io_f3_req_fire commits the f3 lookup; io_f3_pred_in base direction; io_update_* train/repair;
// io_f3_pred final direction; io_f3_meta_s_cnt speculative count used at f3.
module loop_predictor_column
  import loop_predictor_column_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] io_f2_req_idx,
  input  logic             io_f3_req_fire,
  input  logic             io_f3_pred_in,
  input  logic             io_update_mispredict,
  input  logic             io_update_repair,
  input  logic [IDX_W-1:0] io_update_idx,
  input  logic [CNT_W-1:0] io_update_meta_s_cnt,
  output logic             io_f3_pred,
  output logic [CNT_W-1:0] io_f3_meta_s_cnt
);
  loop_entry_t      entries_q [N_SETS];
  logic             doing_reset_q;
  logic [SET_W-1:0] reset_idx_q;
  loop_entry_t      f3_entry_q, f4_entry_q;
  logic [TAG_W-1:0] f3_tag_q, f4_tag_q;
  logic [IDX_W-1:0] f3_idx_q, f4_idx_q;
  logic [CNT_W-1:0] f3_scnt, f4_scnt_q;
  logic             f4_fire_q, f3_hit, f4_hit, f4_we, upd_we, tm, cm;
  loop_entry_t      f4_new, upd_e, upd_new;
  logic [TAG_W-1:0] upd_tag;
  // a repair in flight for the index being predicted overrides the stale table count
  assign f3_scnt = (io_update_repair && io_update_idx == f3_idx_q) ? io_update_meta_s_cnt : f3_entry_q.s_cnt;
  assign f3_hit = f3_entry_q.tag == f3_tag_q && f3_scnt == f3_entry_q.p_cnt && f3_entry_q.conf == CONF_MAX;
  assign io_f3_pred = io_f3_pred_in ^ f3_hit;
  assign io_f3_meta_s_cnt = f3_scnt;
  always_comb begin
    f4_we = f4_fire_q && f4_entry_q.tag == f4_tag_q;
    f4_hit = f4_scnt_q == f4_entry_q.p_cnt && f4_entry_q.conf == CONF_MAX;
    f4_new = f4_entry_q;
    f4_new.s_cnt = f4_hit ? '0 : f4_scnt_q + CNT_W'(1);
    f4_new.age = f4_hit ? 3'd7 : sat_inc(f4_entry_q.age);
  end
  assign upd_e = entries_q[io_update_idx[SET_W-1:0]];
  assign upd_tag = io_update_idx[SET_W +: TAG_W];
  assign tm = upd_e.tag == upd_tag;
  assign cm = upd_e.p_cnt == io_update_meta_s_cnt;
  always_comb begin
    upd_new = upd_e;
    upd_we = 1'b0;
    if (io_update_mispredict && !doing_reset_q) begin
      upd_we = 1'b1;
      if (upd_e.conf == CONF_MAX) begin
        if (tm) begin
          upd_new.conf = 3'd0;
          upd_new.s_cnt = '0;
        end
      end else if (upd_e.conf != 3'd0) begin
        if (tm && cm) begin
          upd_new.conf = upd_e.conf + 3'd1;
          upd_new.s_cnt = '0;
        end else if (tm) begin
          upd_new.conf = 3'd0;
          upd_new.s_cnt = '0;
          upd_new.p_cnt = io_update_meta_s_cnt;
        end else if (upd_e.age == 3'd0) begin
          upd_new.tag = upd_tag;
          upd_new.conf = 3'd1;
          upd_new.s_cnt = '0;
          upd_new.p_cnt = io_update_meta_s_cnt;
        end else begin
          upd_new.age = upd_e.age - 3'd1;
        end
      end else begin
        upd_new.s_cnt = '0;
        upd_new.age = 3'd7;
        if (!tm) begin
          upd_new.tag = upd_tag;
          upd_new.conf = 3'd1;
          upd_new.p_cnt = io_update_meta_s_cnt;
        end else if (cm) begin
          upd_new.conf = 3'd1;
        end else begin
          upd_new.p_cnt = io_update_meta_s_cnt;
        end
      end
    end else if (io_update_repair && !doing_reset_q && tm && !(f4_fire_q && io_update_idx == f4_idx_q)) begin
      upd_we = 1'b1;
      upd_new.s_cnt = io_update_meta_s_cnt;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      doing_reset_q <= 1'b1;
      reset_idx_q <= '0;
      f4_fire_q <= 1'b0;
    end else begin
      doing_reset_q <= doing_reset_q && reset_idx_q != SET_W'(N_SETS - 1);
      reset_idx_q <= doing_reset_q ? reset_idx_q + SET_W'(1) : reset_idx_q;
      f4_fire_q <= io_f3_req_fire;
    end
  end
  always_ff @(posedge clock) begin
    f3_entry_q <= entries_q[io_f2_req_idx[SET_W-1:0]];
    f3_tag_q <= io_f2_req_idx[SET_W +: TAG_W];
    f3_idx_q <= io_f2_req_idx;
    f4_entry_q <= f3_entry_q;
    f4_tag_q <= f3_tag_q;
    f4_scnt_q <= f3_scnt;
    f4_idx_q <= f3_idx_q;
  end
  // later writes win: f4 step < mispredict/repair < reset sweep
  always_ff @(posedge clock) begin
    if (f4_we) entries_q[f4_idx_q[SET_W-1:0]] <= f4_new;
    if (upd_we) entries_q[io_update_idx[SET_W-1:0]] <= upd_new;
    if (doing_reset_q) entries_q[reset_idx_q] <= '0;
  end
endmodule

// File: tb/tb_loop_predictor_column.sv
// tb_loop_predictor_column: directed self-checking bench for loop_predictor_column
module tb_loop_predictor_column;
  import loop_predictor_column_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [35:0] f2_idx = '0;
  logic fire = 1'b0;
  logic pred_in = 1'b0;
  logic upd_mis = 1'b0;
  logic upd_rep = 1'b0;
  logic [35:0] upd_idx = '0;
  logic [9:0] upd_meta = '0;
  logic f3_pred;
  logic [9:0] f3_meta;
  int checks = 0;
  int errors = 0;
  loop_predictor_column dut (
    .clock(clk),
    .reset(rst),
    .io_f2_req_idx(f2_idx),
    .io_f3_req_fire(fire),
    .io_f3_pred_in(pred_in),
    .io_update_mispredict(upd_mis),
    .io_update_repair(upd_rep),
    .io_update_idx(upd_idx),
    .io_update_meta_s_cnt(upd_meta),
    .io_f3_pred(f3_pred),
    .io_f3_meta_s_cnt(f3_meta)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  function automatic loop_entry_t ent(input logic [9:0] t, input logic [2:0] c, input logic [2:0] a,
                                      input logic [9:0] p, input logic [9:0] s);
    return '{tag: t, conf: c, age: a, p_cnt: p, s_cnt: s};
  endfunction
  task automatic chk_ent(input string tag, input int s, input loop_entry_t exp);
    chk(tag, 64'(dut.entries_q[s]), 64'(exp));
  endtask
  task automatic mispredict(input logic [35:0] idx, input logic [9:0] meta);
    upd_mis = 1'b1;
    upd_idx = idx;
    upd_meta = meta;
    step();
    upd_mis = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("doing_reset_after_reset", 64'(dut.doing_reset_q), 64'd1);
    repeat (16) step();
    chk("doing_reset_after_sweep", 64'(dut.doing_reset_q), 64'd0);
    f2_idx = 36'h123;
    pred_in = 1'b1;
    step();
    chk("first_pred", 64'(f3_pred), 64'd1);
    chk("first_meta", 64'(f3_meta), 64'd0);
    mispredict(36'h123, 10'd5);
    chk_ent("alloc_entry", 3, ent(10'h12, 3'd1, 3'd7, 10'd5, 10'd0));
    repeat (6) mispredict(36'h123, 10'd5);
    chk_ent("learned_entry", 3, ent(10'h12, 3'd7, 3'd7, 10'd5, 10'd0));
    step();
    for (int k = 0; k < 6; k++) begin
      fire = 1'b1;
      #1;
      chk($sformatf("loop_meta_%0d", k), 64'(f3_meta), 64'(k));
      chk($sformatf("loop_pred_%0d", k), 64'(f3_pred), (k == 5) ? 64'd0 : 64'd1);
      step();
      fire = 1'b0;
      step();
      step();
    end
    chk("wrap_meta", 64'(f3_meta), 64'd0);
    chk("wrap_pred", 64'(f3_pred), 64'd1);
    chk_ent("after_trip", 3, ent(10'h12, 3'd7, 3'd7, 10'd5, 10'd0));
    mispredict(36'h123, 10'd5);
    chk_ent("learned_mispredict", 3, ent(10'h12, 3'd0, 3'd7, 10'd5, 10'd0));
    mispredict(36'h123, 10'd5);
    chk_ent("reconfirm", 3, ent(10'h12, 3'd1, 3'd7, 10'd5, 10'd0));
    repeat (4) mispredict(36'h223, 10'd5);
    chk_ent("aged_to_3", 3, ent(10'h12, 3'd1, 3'd3, 10'd5, 10'd0));
    mispredict(36'h223, 10'd5);
    chk_ent("aged_to_2", 3, ent(10'h12, 3'd1, 3'd2, 10'd5, 10'd0));
    step();
    upd_rep = 1'b1;
    upd_idx = 36'h123;
    upd_meta = 10'd9;
    #1;
    chk("repair_meta_fwd", 64'(f3_meta), 64'd9);
    step();
    upd_rep = 1'b0;
    chk_ent("repair_write", 3, ent(10'h12, 3'd1, 3'd2, 10'd5, 10'd9));
    step();
    fire = 1'b1;
    #1;
    chk("meta_after_repair", 64'(f3_meta), 64'd9);
    step();
    fire = 1'b0;
    upd_rep = 1'b1;
    upd_meta = 10'd20;
    #1;
    chk("repair_meta_fwd2", 64'(f3_meta), 64'd20);
    step();
    upd_rep = 1'b0;
    chk_ent("repair_blocked_by_f4", 3, ent(10'h12, 3'd1, 3'd3, 10'd5, 10'd10));
    rst = 1'b1;
    step();
    rst = 1'b0;
    upd_mis = 1'b1;
    upd_idx = 36'h123;
    upd_meta = 10'd5;
    repeat (16) step();
    upd_mis = 1'b0;
    for (int i = 0; i < 16; i++) chk_ent($sformatf("swept_%0d", i), i, ent(10'h0, 3'd0, 3'd0, 10'd0, 10'd0));
    #1;
    chk("post_sweep_pred", 64'(f3_pred), 64'd1);
    chk("post_sweep_meta", 64'(f3_meta), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
